// File: rtl/score_keeper_if.sv
// Score keeper bus: button/strobe inputs toward the counter and BCD score/match status back.
interface score_keeper_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned DIGITS      = 2
);
  logic                          clr;
  logic [NUM_PLAYERS-1:0]        inc;
  logic [NUM_PLAYERS-1:0]        dec;
  logic [NUM_PLAYERS*DIGITS*4-1:0] score_bcd;
  logic [NUM_PLAYERS-1:0]        changed;
  logic                          match_over;
  logic [NUM_PLAYERS-1:0]        winner;

  modport master (
    output clr, inc, dec,
    input  score_bcd, changed, match_over, winner
  );

  modport slave (
    input  clr, inc, dec,
    output score_bcd, changed, match_over, winner
  );
endinterface

// File: rtl/score_keeper.sv
// Multi-player BCD score counter with per-press edge detection and a win-target match FSM.
module score_keeper #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned WIN_SCORE   = 10,
  parameter bit          WRAP        = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  score_keeper_if.slave  bus
);

  localparam int unsigned W = DIGITS * 4;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  localparam int unsigned  MAX_SCORE = pow10(DIGITS) - 1;
  localparam logic [W-1:0] ALL9      = to_bcd(MAX_SCORE);
  localparam logic [W-1:0] WIN_BCD   = to_bcd(WIN_SCORE);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_bad_players
    $error("score_keeper: NUM_PLAYERS must be 1..8");
  end
  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("score_keeper: DIGITS must be 1..4");
  end
  if (WIN_SCORE > MAX_SCORE) begin : g_bad_win
    $error("score_keeper: WIN_SCORE does not fit in DIGITS BCD digits");
  end

  // Ripple carry through the digits; caller handles the all-9s case.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  typedef enum logic {PLAY, OVER} state_e;

  state_e                       state_q, state_d;
  logic [NUM_PLAYERS*W-1:0]     score_q, score_d;
  logic [NUM_PLAYERS-1:0]       changed_q, changed_d;
  logic [NUM_PLAYERS-1:0]       winner_q, winner_d;
  logic [NUM_PLAYERS-1:0]       inc_q, dec_q;
  logic [NUM_PLAYERS-1:0]       inc_rise, dec_rise, hit;
  logic [W-1:0]                 cur, nxt;

  assign inc_rise = bus.inc & ~inc_q;
  assign dec_rise = bus.dec & ~dec_q;

  // Edge registers preset to ones so a button held through reset is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PLAY;
      score_q   <= '0;
      changed_q <= '0;
      winner_q  <= '0;
      inc_q     <= '1;
      dec_q     <= '1;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      changed_q <= changed_d;
      winner_q  <= winner_d;
      inc_q     <= bus.inc;
      dec_q     <= bus.dec;
    end
  end

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    changed_d = '0;
    winner_d  = winner_q;
    hit       = '0;
    cur       = '0;
    nxt       = '0;
    if (bus.clr) begin
      state_d  = PLAY;
      score_d  = '0;
      winner_d = '0;
    end else if (state_q == PLAY) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        cur = score_q[p*W +: W];
        nxt = cur;
        if (inc_rise[p] && !dec_rise[p]) begin
          if (cur != ALL9) nxt = bcd_inc(cur);
          else if (WRAP)   nxt = '0;
        end else if (dec_rise[p] && !inc_rise[p]) begin
          if (cur != '0) nxt = bcd_dec(cur);
        end
        score_d[p*W +: W] = nxt;
        changed_d[p]      = (nxt != cur);
        hit[p]            = (WIN_SCORE != 0) && (nxt == WIN_BCD);
      end
      if (|hit) begin
        state_d  = OVER;
        winner_d = hit;
      end
    end
  end

  assign bus.score_bcd  = score_q;
  assign bus.changed    = changed_q;
  assign bus.match_over = (state_q == OVER);
  assign bus.winner     = winner_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: four configurations checked every cycle against an integer reference model.
module tb_score_keeper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       clr   = 1'b0;
  logic [1:0] inc_a = '0, dec_a = '0;
  logic [1:0] inc_b = '0, dec_b = '0;

  int n_checks = 0;
  int n_errors = 0;

  score_keeper_if #(.NUM_PLAYERS(2), .DIGITS(2)) bus0 ();
  score_keeper_if #(.NUM_PLAYERS(2), .DIGITS(1)) bus1 ();
  score_keeper_if #(.NUM_PLAYERS(2), .DIGITS(1)) bus2 ();
  score_keeper_if #(.NUM_PLAYERS(2), .DIGITS(2)) bus3 ();

  assign bus0.clr = clr; assign bus0.inc = inc_a; assign bus0.dec = dec_a;
  assign bus3.clr = clr; assign bus3.inc = inc_a; assign bus3.dec = dec_a;
  assign bus1.clr = clr; assign bus1.inc = inc_b; assign bus1.dec = dec_b;
  assign bus2.clr = clr; assign bus2.inc = inc_b; assign bus2.dec = dec_b;

  score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(10), .WRAP(1'b0))
    dut0 (.clk(clk), .reset(rst), .bus(bus0));
  score_keeper #(.NUM_PLAYERS(2), .DIGITS(1), .WIN_SCORE(0), .WRAP(1'b0))
    dut1 (.clk(clk), .reset(rst), .bus(bus1));
  score_keeper #(.NUM_PLAYERS(2), .DIGITS(1), .WIN_SCORE(0), .WRAP(1'b1))
    dut2 (.clk(clk), .reset(rst), .bus(bus2));
  score_keeper #(.NUM_PLAYERS(2), .DIGITS(2), .WIN_SCORE(0), .WRAP(1'b0))
    dut3 (.clk(clk), .reset(rst), .bus(bus3));

  // ---------------- reference model (decimal integers) ----------------
  int cfg_d[4]    = '{2, 1, 1, 2};
  int cfg_win[4]  = '{10, 0, 0, 0};
  bit cfg_wrap[4] = '{0, 0, 1, 0};

  int       m_s[4][2];
  bit       m_pi[4][2], m_pd[4][2];
  bit       m_ov[4];
  bit [1:0] m_wn[4], m_ch[4];

  typedef struct {
    int       s0;
    int       s1;
    bit [1:0] ch;
    bit       ov;
    bit [1:0] wn;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];

  function automatic int pow10(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic void model_reset(int k);
    for (int p = 0; p < 2; p++) begin
      m_s[k][p] = 0; m_pi[k][p] = 1; m_pd[k][p] = 1;
    end
    m_ov[k] = 0; m_wn[k] = 0; m_ch[k] = 0;
  endfunction

  function automatic void model_step(int k, logic c, logic [1:0] inc, logic [1:0] dec);
    int       mx = pow10(cfg_d[k]) - 1;
    int       n;
    bit       ri, rd;
    bit [1:0] hit = 0;
    m_ch[k] = 0;
    if (c) begin
      m_s[k][0] = 0; m_s[k][1] = 0; m_ov[k] = 0; m_wn[k] = 0;
    end else if (!m_ov[k]) begin
      for (int p = 0; p < 2; p++) begin
        ri = inc[p] && !m_pi[k][p];
        rd = dec[p] && !m_pd[k][p];
        n  = m_s[k][p];
        if (ri && !rd)      n = (n < mx) ? n + 1 : (cfg_wrap[k] ? 0 : n);
        else if (rd && !ri) n = (n > 0) ? n - 1 : 0;
        if (n != m_s[k][p]) m_ch[k][p] = 1;
        m_s[k][p] = n;
        if (cfg_win[k] != 0 && n == cfg_win[k]) hit[p] = 1;
      end
      if (hit != 0) begin m_ov[k] = 1; m_wn[k] = hit; end
    end
    for (int p = 0; p < 2; p++) begin
      m_pi[k][p] = inc[p]; m_pd[k][p] = dec[p];
    end
  endfunction

  function automatic exp_t snap(int k);
    exp_t e;
    e.s0 = m_s[k][0]; e.s1 = m_s[k][1];
    e.ch = m_ch[k]; e.ov = m_ov[k]; e.wn = m_ov[k] ? m_wn[k] : 2'b00;
    return e;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) model_reset(k);
    end else begin
      model_step(0, clr, inc_a, dec_a);
      model_step(3, clr, inc_a, dec_a);
      model_step(1, clr, inc_b, dec_b);
      model_step(2, clr, inc_b, dec_b);
    end
    q0.push_back(snap(0)); q1.push_back(snap(1));
    q2.push_back(snap(2)); q3.push_back(snap(3));
  end

  // ---------------- monitor ----------------
  function automatic int bcd2int(logic [15:0] v, int d);
    int r = 0;
    for (int i = d - 1; i >= 0; i--) begin
      if (v[i*4 +: 4] > 4'd9) return -1;
      r = r * 10 + int'(v[i*4 +: 4]);
    end
    return r;
  endfunction

  function automatic void compare(string name, exp_t e, int s0, int s1,
                                  logic [1:0] ch, logic ov, logic [1:0] wn);
    n_checks++;
    if (s0 !== e.s0 || s1 !== e.s1 || ch !== e.ch || ov !== e.ov || wn !== e.wn) begin
      n_errors++;
      $display("FAIL %s @%0t: got s=%0d/%0d ch=%b ov=%b wn=%b, expected s=%0d/%0d ch=%b ov=%b wn=%b",
               name, $time, s0, s1, ch, ov, wn, e.s0, e.s1, e.ch, e.ov, e.wn);
    end
  endfunction

  function automatic void empty_fail(string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: scoreboard queue empty when output sampled", name);
  endfunction

  always @(posedge clk or posedge rst) begin
    #1;
    if (q0.size() == 0) empty_fail("dut0");
    else compare("dut0", q0.pop_front(), bcd2int({8'h00, bus0.score_bcd[7:0]}, 2),
                 bcd2int({8'h00, bus0.score_bcd[15:8]}, 2), bus0.changed, bus0.match_over, bus0.winner);
    if (q1.size() == 0) empty_fail("dut1");
    else compare("dut1", q1.pop_front(), bcd2int({12'h000, bus1.score_bcd[3:0]}, 1),
                 bcd2int({12'h000, bus1.score_bcd[7:4]}, 1), bus1.changed, bus1.match_over, bus1.winner);
    if (q2.size() == 0) empty_fail("dut2");
    else compare("dut2", q2.pop_front(), bcd2int({12'h000, bus2.score_bcd[3:0]}, 1),
                 bcd2int({12'h000, bus2.score_bcd[7:4]}, 1), bus2.changed, bus2.match_over, bus2.winner);
    if (q3.size() == 0) empty_fail("dut3");
    else compare("dut3", q3.pop_front(), bcd2int({8'h00, bus3.score_bcd[7:0]}, 2),
                 bcd2int({8'h00, bus3.score_bcd[15:8]}, 2), bus3.changed, bus3.match_over, bus3.winner);
  end

  // ---------------- directed checks and stimulus ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic press_a(input logic [1:0] i, input logic [1:0] d);
    @(negedge clk); inc_a = i; dec_a = d;
    @(negedge clk); inc_a = '0; dec_a = '0;
  endtask

  task automatic press_b(input logic [1:0] i, input logic [1:0] d);
    @(negedge clk); inc_b = i; dec_b = d;
    @(negedge clk); inc_b = '0; dec_b = '0;
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("reset_score0", 32'(bus0.score_bcd), 32'h0);
    chk("reset_over0", 32'(bus0.match_over), 32'h0);

    // long hold counts once
    @(negedge clk); inc_a = 2'b01;
    repeat (50) @(negedge clk);
    chk("hold_once", 32'(bus0.score_bcd[7:0]), 32'h01);
    inc_a = '0;
    do_clr();

    // carry/borrow on the no-target 2-digit instance; default instance wins at 10
    repeat (9) press_a(2'b10, 2'b00);
    chk("p1_nine", 32'(bus0.score_bcd[15:8]), 32'h09);
    press_a(2'b10, 2'b00);
    chk("carry", 32'(bus3.score_bcd[15:8]), 32'h10);
    chk("win_p1", 32'({bus0.match_over, bus0.winner}), 32'b110);
    press_a(2'b00, 2'b10);
    chk("borrow", 32'(bus3.score_bcd[15:8]), 32'h09);
    chk("over_frozen", 32'(bus0.score_bcd[15:8]), 32'h10);
    do_clr();
    press_a(2'b00, 2'b10);
    chk("dec_at_zero", 32'(bus3.score_bcd[15:8]), 32'h00);

    repeat (10) press_a(2'b01, 2'b00);
    chk("win_p0", 32'({bus0.match_over, bus0.winner}), 32'b101);
    press_a(2'b10, 2'b01);
    chk("over_ignore", 32'(bus0.score_bcd), 32'h0010);
    do_clr();
    chk("clr_over", 32'(bus0.match_over), 32'h0);
    chk("clr_score", 32'(bus0.score_bcd), 32'h0);

    repeat (9) press_a(2'b11, 2'b00);
    press_a(2'b11, 2'b00);
    chk("tie", 32'({bus0.match_over, bus0.winner}), 32'b111);
    chk("tie_score", 32'(bus0.score_bcd), 32'h1010);
    do_clr();

    // single digit saturate / wrap / simultaneous inc+dec
    repeat (9) press_b(2'b01, 2'b00);
    press_b(2'b01, 2'b00);
    chk("sat_hold", 32'(bus1.score_bcd[3:0]), 32'h9);
    chk("wrap_zero", 32'(bus2.score_bcd[3:0]), 32'h0);
    press_b(2'b10, 2'b00);
    press_b(2'b10, 2'b10);
    chk("inc_dec_same", 32'(bus1.score_bcd[7:4]), 32'h1);

    // input held through reset release is not counted
    @(negedge clk); inc_a = 2'b01; inc_b = 2'b01;
    #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_thru_reset", 32'(bus0.score_bcd), 32'h0);
    inc_a = '0; inc_b = '0;

    // asynchronous reset from OVER
    repeat (10) press_a(2'b01, 2'b00);
    chk("pre_reset_over", 32'(bus0.match_over), 32'h1);
    #2 rst = 1'b1;
    #1 chk("async_reset", 32'({bus0.score_bcd, bus0.changed, bus0.match_over, bus0.winner}), 32'h0);
    @(negedge clk); #2 rst = 1'b0;

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      clr   = ($urandom_range(0, 63) == 0);
      inc_a = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      dec_a = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      inc_b = 2'($urandom_range(0, 3));
      dec_b = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
    end
    @(negedge clk); clr = 1'b0; inc_a = '0; dec_a = '0; inc_b = '0; dec_b = '0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
